neander_x_control: RTL and testbench

Moore-style sequencer for the NEANDER-X CPU. It fetches, decodes and executes one instruction at a time by driving every control input of `neander_datapath` from a single state register. Its inputs are the instruction register fields (`opcode`, `sub_opcode`) and the N/Z flags. The block sits beside the datapath in the CPU top level and shares its clock.

---
 rtl/neander_x_control_if.sv | 46 ++++
 rtl/neander_x_control.sv | 199 +++++++++++++++++++
 tb/tb_neander_x_control.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/neander_x_control_if.sv
// neander_x_control_if
// Bundle of signals between the NEANDER-X sequencer and its datapath.
//   Inputs to the sequencer (driven by the datapath):
//     opcode[3:0], sub_opcode[3:0] : instruction register fields
//     flagN, flagZ                 : datapath condition flags
//   Outputs from the sequencer (consumed by the datapath):
//     mem_read, mem_write, pc_inc, pc_load, ac_load, ri_load, rem_load,
//     rdm_load, nz_load, addr_sel[1:0], alu_op[1:0], sp_inc, sp_dec,
//     mem_data_sel, io_write_ctrl, halted
// modport master is the sequencer side, modport slave the datapath side.
interface neander_x_control_if;
    logic [3:0] opcode;
    logic [3:0] sub_opcode;
    logic       flagN;
    logic       flagZ;
    logic       mem_read;
    logic       mem_write;
    logic       pc_inc;
    logic       pc_load;
    logic       ac_load;
    logic       ri_load;
    logic       rem_load;
    logic       rdm_load;
    logic       nz_load;
    logic [1:0] addr_sel;
    logic [1:0] alu_op;
    logic       sp_inc;
    logic       sp_dec;
    logic       mem_data_sel;
    logic       io_write_ctrl;
    logic       halted;

    modport master (
        input  opcode, sub_opcode, flagN, flagZ,
        output mem_read, mem_write, pc_inc, pc_load, ac_load, ri_load,
               rem_load, rdm_load, nz_load, addr_sel, alu_op, sp_inc,
               sp_dec, mem_data_sel, io_write_ctrl, halted
    );

    modport slave (
        output opcode, sub_opcode, flagN, flagZ,
        input  mem_read, mem_write, pc_inc, pc_load, ac_load, ri_load,
               rem_load, rdm_load, nz_load, addr_sel, alu_op, sp_inc,
               sp_dec, mem_data_sel, io_write_ctrl, halted
    );
endinterface

// File: rtl/neander_x_control.sv
// neander_x_control
// Moore sequencer for the NEANDER-X CPU: fetch, decode and execute one
// instruction at a time, driving every datapath control from one state
// register.
//   clk   : system clock, rising edge
//   reset : synchronous, active low; also forces all outputs to 0 while low
//   bus   : neander_x_control_if.master (instruction fields and flags in,
//           datapath control strobes out)
module neander_x_control (
    input  logic                       clk,
    input  logic                       reset,
    neander_x_control_if.master        bus
);

    // The ALU and IO terminal states are split per operation so that every
    // output is a function of the state alone.
    typedef enum logic [4:0] {
        F1, F2, F3, DEC,
        A1, A2, A3,
        STW, EXM_ADD, EXM_AND, EXM_OR, NOTX,
        JP, SKIP, LDX, IOX_IN, IOX_OUT,
        SPD, SPA, SWR, PRD, CWR, RRD,
        HALT
    } state_t;

    state_t state_q, state_d;

    // State register; reset restarts fetch, abandoning any instruction.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= F1;
        else        state_q <= state_d;
    end

    // Next-state logic. Shared states pick their successor from RI, which
    // only changes in F3, so the fields are stable for the whole instruction.
    always_comb begin
        state_d = F1;
        case (state_q)
            F1:  state_d = F2;
            F2:  state_d = F3;
            F3:  state_d = DEC;
            DEC: begin
                case (bus.opcode)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                    4'h8, 4'hC, 4'hD, 4'hE: state_d = A1;
                    4'h6:                   state_d = NOTX;
                    4'h9:                   state_d = bus.flagN ? A1 : SKIP;
                    4'hA:                   state_d = bus.flagZ ? A1 : SKIP;
                    4'h7: begin
                        case (bus.sub_opcode)
                            4'h0:    state_d = SPD;
                            4'h1:    state_d = SPA;
                            4'h2:    state_d = A1;
                            4'h3:    state_d = SPA;
                            default: state_d = F1;
                        endcase
                    end
                    4'hF:                   state_d = HALT;
                    default:                state_d = F1;
                endcase
            end
            A1:  state_d = (bus.opcode == 4'hE) ? LDX : A2;
            A2: begin
                case (bus.opcode)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5: state_d = A3;
                    4'h8, 4'h9, 4'hA:             state_d = JP;
                    4'hC:                         state_d = IOX_IN;
                    4'hD:                         state_d = IOX_OUT;
                    4'h7:                         state_d = SPD;
                    default:                      state_d = F1;
                endcase
            end
            A3: begin
                case (bus.opcode)
                    4'h1:    state_d = STW;
                    4'h4:    state_d = EXM_OR;
                    4'h5:    state_d = EXM_AND;
                    default: state_d = EXM_ADD;
                endcase
            end
            SPD: state_d = SPA;
            SPA: begin
                case (bus.sub_opcode)
                    4'h0:    state_d = SWR;
                    4'h1:    state_d = PRD;
                    4'h2:    state_d = CWR;
                    4'h3:    state_d = RRD;
                    default: state_d = F1;
                endcase
            end
            RRD:  state_d = JP;
            HALT: state_d = HALT;
            default: state_d = F1;
        endcase
    end

    // Output decode from the state register. The final reset gate keeps the
    // datapath quiet while reset is held, even though the state is already F1.
    always_comb begin
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.pc_inc        = 1'b0;
        bus.pc_load       = 1'b0;
        bus.ac_load       = 1'b0;
        bus.ri_load       = 1'b0;
        bus.rem_load      = 1'b0;
        bus.rdm_load      = 1'b0;
        bus.nz_load       = 1'b0;
        bus.addr_sel      = 2'b00;
        bus.alu_op        = 2'b00;
        bus.sp_inc        = 1'b0;
        bus.sp_dec        = 1'b0;
        bus.mem_data_sel  = 1'b0;
        bus.io_write_ctrl = 1'b0;
        bus.halted        = 1'b0;
        case (state_q)
            F1, A1: begin
                bus.addr_sel = 2'b01;
                bus.rem_load = 1'b1;
            end
            F2, A2: begin
                bus.mem_read = 1'b1;
                bus.rdm_load = 1'b1;
                bus.pc_inc   = 1'b1;
            end
            F3:   bus.ri_load  = 1'b1;
            A3:   bus.rem_load = 1'b1;
            STW:  bus.mem_write = 1'b1;
            EXM_ADD, EXM_AND, EXM_OR: begin
                bus.mem_read = 1'b1;
                bus.ac_load  = 1'b1;
                bus.nz_load  = 1'b1;
                if (state_q == EXM_AND) bus.alu_op = 2'b01;
                if (state_q == EXM_OR)  bus.alu_op = 2'b10;
            end
            NOTX: begin
                bus.ac_load = 1'b1;
                bus.nz_load = 1'b1;
                bus.alu_op  = 2'b11;
            end
            JP:   bus.pc_load = 1'b1;
            SKIP: bus.pc_inc  = 1'b1;
            LDX: begin
                bus.mem_read = 1'b1;
                bus.ac_load  = 1'b1;
                bus.nz_load  = 1'b1;
                bus.pc_inc   = 1'b1;
            end
            IOX_IN: begin
                bus.ac_load = 1'b1;
                bus.nz_load = 1'b1;
            end
            IOX_OUT: bus.io_write_ctrl = 1'b1;
            SPD:     bus.sp_dec = 1'b1;
            SPA: begin
                bus.addr_sel = 2'b10;
                bus.rem_load = 1'b1;
            end
            SWR: bus.mem_write = 1'b1;
            PRD: begin
                bus.mem_read = 1'b1;
                bus.ac_load  = 1'b1;
                bus.nz_load  = 1'b1;
                bus.sp_inc   = 1'b1;
            end
            CWR: begin
                bus.mem_write    = 1'b1;
                bus.mem_data_sel = 1'b1;
                bus.pc_load      = 1'b1;
            end
            RRD: begin
                bus.mem_read = 1'b1;
                bus.rdm_load = 1'b1;
                bus.sp_inc   = 1'b1;
            end
            HALT: bus.halted = 1'b1;
            default: ;
        endcase
        if (!reset) begin
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.pc_inc        = 1'b0;
            bus.pc_load       = 1'b0;
            bus.ac_load       = 1'b0;
            bus.ri_load       = 1'b0;
            bus.rem_load      = 1'b0;
            bus.rdm_load      = 1'b0;
            bus.nz_load       = 1'b0;
            bus.addr_sel      = 2'b00;
            bus.alu_op        = 2'b00;
            bus.sp_inc        = 1'b0;
            bus.sp_dec        = 1'b0;
            bus.mem_data_sel  = 1'b0;
            bus.io_write_ctrl = 1'b0;
            bus.halted        = 1'b0;
        end
    end

endmodule

// File: tb/tb_neander_x_control.sv
// tb_neander_x_control
// Bench for neander_x_control: random instruction stream compared cycle by
// cycle against a per-instruction list of expected control words, plus
// reset, mid-instruction abort and HLT scenarios.
module tb_neander_x_control;

    typedef bit [17:0] vec_t;
    typedef vec_t vecq_t[$];

    // Control word layout:
    // {mem_read, mem_write, pc_inc, pc_load, ac_load, ri_load, rem_load,
    //  rdm_load, nz_load, addr_sel[1:0], alu_op[1:0], sp_inc, sp_dec,
    //  mem_data_sel, io_write_ctrl, halted}
    localparam vec_t MR    = vec_t'(1) << 17;
    localparam vec_t MW    = vec_t'(1) << 16;
    localparam vec_t PCI   = vec_t'(1) << 15;
    localparam vec_t PCL   = vec_t'(1) << 14;
    localparam vec_t ACL   = vec_t'(1) << 13;
    localparam vec_t RIL   = vec_t'(1) << 12;
    localparam vec_t REML  = vec_t'(1) << 11;
    localparam vec_t RDML  = vec_t'(1) << 10;
    localparam vec_t NZL   = vec_t'(1) << 9;
    localparam vec_t ASPC  = vec_t'(1) << 7;
    localparam vec_t ASSP  = vec_t'(2) << 7;
    localparam vec_t ALAND = vec_t'(1) << 5;
    localparam vec_t ALOR  = vec_t'(2) << 5;
    localparam vec_t ALNOT = vec_t'(3) << 5;
    localparam vec_t SPI   = vec_t'(1) << 4;
    localparam vec_t SPDN  = vec_t'(1) << 3;
    localparam vec_t MDS   = vec_t'(1) << 2;
    localparam vec_t IOW   = vec_t'(1) << 1;
    localparam vec_t HLTD  = vec_t'(1);

    localparam vec_t FETCH_ADDR = REML | ASPC;
    localparam vec_t FETCH_READ = MR | RDML | PCI;
    localparam vec_t STACK_ADDR = REML | ASSP;

    logic clk;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    neander_x_control_if bus ();

    neander_x_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t observed();
        return {bus.mem_read, bus.mem_write, bus.pc_inc, bus.pc_load,
                bus.ac_load, bus.ri_load, bus.rem_load, bus.rdm_load,
                bus.nz_load, bus.addr_sel, bus.alu_op, bus.sp_inc,
                bus.sp_dec, bus.mem_data_sel, bus.io_write_ctrl, bus.halted};
    endfunction

    // Reference model: the instruction's control words, one per cycle from
    // F1 to its terminal state, written straight from the instruction table.
    function automatic vecq_t buildSeq(input bit [3:0] op, input bit [3:0] sub,
                                       input bit n, input bit z);
        vecq_t q;
        q.push_back(FETCH_ADDR);
        q.push_back(FETCH_READ);
        q.push_back(RIL);
        q.push_back('0);
        case (op)
            4'h1: begin
                q.push_back(FETCH_ADDR); q.push_back(FETCH_READ);
                q.push_back(REML);       q.push_back(MW);
            end
            4'h2, 4'h3: begin
                q.push_back(FETCH_ADDR); q.push_back(FETCH_READ);
                q.push_back(REML);       q.push_back(MR | ACL | NZL);
            end
            4'h4: begin
                q.push_back(FETCH_ADDR); q.push_back(FETCH_READ);
                q.push_back(REML);       q.push_back(MR | ACL | NZL | ALOR);
            end
            4'h5: begin
                q.push_back(FETCH_ADDR); q.push_back(FETCH_READ);
                q.push_back(REML);       q.push_back(MR | ACL | NZL | ALAND);
            end
            4'h6: q.push_back(ACL | NZL | ALNOT);
            4'h8: begin
                q.push_back(FETCH_ADDR); q.push_back(FETCH_READ); q.push_back(PCL);
            end
            4'h9, 4'hA: begin
                if ((op == 4'h9) ? n : z) begin
                    q.push_back(FETCH_ADDR); q.push_back(FETCH_READ); q.push_back(PCL);
                end else begin
                    q.push_back(PCI);
                end
            end
            4'hE: begin
                q.push_back(FETCH_ADDR); q.push_back(MR | ACL | NZL | PCI);
            end
            4'hC: begin
                q.push_back(FETCH_ADDR); q.push_back(FETCH_READ); q.push_back(ACL | NZL);
            end
            4'hD: begin
                q.push_back(FETCH_ADDR); q.push_back(FETCH_READ); q.push_back(IOW);
            end
            4'h7: begin
                case (sub)
                    4'h0: begin
                        q.push_back(SPDN); q.push_back(STACK_ADDR); q.push_back(MW);
                    end
                    4'h1: begin
                        q.push_back(STACK_ADDR); q.push_back(MR | ACL | NZL | SPI);
                    end
                    4'h2: begin
                        q.push_back(FETCH_ADDR); q.push_back(FETCH_READ);
                        q.push_back(SPDN);       q.push_back(STACK_ADDR);
                        q.push_back(MW | MDS | PCL);
                    end
                    4'h3: begin
                        q.push_back(STACK_ADDR); q.push_back(MR | RDML | SPI);
                        q.push_back(PCL);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        return q;
    endfunction

    task automatic checkOutput(input string tag, input vec_t expected);
        vec_t obs;
        obs = observed();
        checks++;
        assert (obs === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%05h expected=%05h", tag, obs, expected);
        end
    endtask

    // Holds reset low for the given number of edges, checking the outputs
    // stay quiet, then releases it and expects the F1 word at once.
    task automatic resetAndRelease(input int cycles);
        reset = 1'b0;
        #1;
        checkOutput("reset_assert", '0);
        repeat (cycles) begin
            @(posedge clk); #1;
            checkOutput("reset_hold", '0);
        end
        reset = 1'b1;
        #1;
        checkOutput("reset_release_f1", FETCH_ADDR);
    endtask

    // Runs one instruction starting in F1. Flags are scrambled after DEC to
    // confirm they are only sampled there. abortAt >= 0 drops reset at that
    // cycle index instead of finishing the instruction.
    task automatic applyStimulus(input bit [3:0] op, input bit [3:0] sub,
                                 input bit n, input bit z, input int abortAt);
        vecq_t exp;
        string tag;
        exp = buildSeq(op, sub, n, z);
        bus.opcode     = op;
        bus.sub_opcode = sub;
        bus.flagN      = n;
        bus.flagZ      = z;
        for (int i = 0; i < exp.size(); i++) begin
            if (i == abortAt) begin
                resetAndRelease(1);
                return;
            end
            tag = $sformatf("op%h_%h_cyc%0d", op, sub, i);
            checkOutput(tag, exp[i]);
            if (i >= 4) begin
                bus.flagN = 1'($urandom);
                bus.flagZ = 1'($urandom);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bit [3:0] op;
        bit [3:0] sub;
        reset          = 1'b0;
        bus.opcode     = 4'h0;
        bus.sub_opcode = 4'h0;
        bus.flagN      = 1'b0;
        bus.flagZ      = 1'b0;
        @(posedge clk); #1;
        resetAndRelease(3);

        // Directed: every opcode once, both branch outcomes, all stack ops.
        applyStimulus(4'h0, 4'h0, 0, 0, -1);
        applyStimulus(4'h2, 4'h0, 0, 0, -1);
        applyStimulus(4'h3, 4'h0, 0, 0, -1);
        applyStimulus(4'h1, 4'h0, 0, 0, -1);
        applyStimulus(4'hE, 4'h0, 0, 0, -1);
        applyStimulus(4'hA, 4'h0, 0, 1, -1);
        applyStimulus(4'hA, 4'h0, 1, 0, -1);
        applyStimulus(4'h9, 4'h0, 1, 0, -1);
        applyStimulus(4'h9, 4'h0, 0, 1, -1);
        applyStimulus(4'h7, 4'h0, 0, 0, -1);
        applyStimulus(4'h7, 4'h1, 0, 0, -1);
        applyStimulus(4'h7, 4'h2, 0, 0, -1);
        applyStimulus(4'h7, 4'h3, 0, 0, -1);
        applyStimulus(4'h7, 4'h9, 0, 0, -1);
        applyStimulus(4'hB, 4'h0, 0, 0, -1);
        applyStimulus(4'h4, 4'h0, 0, 0, -1);
        applyStimulus(4'h5, 4'h0, 0, 0, -1);
        applyStimulus(4'h6, 4'h0, 0, 0, -1);
        applyStimulus(4'h8, 4'h0, 0, 0, -1);
        applyStimulus(4'hC, 4'h0, 0, 0, -1);
        applyStimulus(4'hD, 4'h0, 0, 0, -1);

        // Reset during A2 of an LDA: no ac_load, fetch restarts at F1.
        applyStimulus(4'h2, 4'h0, 0, 0, 5);
        applyStimulus(4'h2, 4'h0, 0, 0, -1);

        // Random instruction stream, HLT excluded so the run keeps going.
        for (int k = 0; k < 80; k++) begin
            op  = 4'($urandom_range(0, 14));
            sub = (op == 4'h7 && $urandom_range(0, 3) != 0)
                  ? 4'($urandom_range(0, 3)) : 4'($urandom);
            applyStimulus(op, sub, 1'($urandom), 1'($urandom), -1);
        end

        // Random mid-instruction aborts.
        for (int k = 0; k < 8; k++) begin
            op  = 4'($urandom_range(0, 14));
            sub = 4'($urandom_range(0, 3));
            applyStimulus(op, sub, 1'($urandom), 1'($urandom),
                          $urandom_range(1, 4));
            applyStimulus(4'h0, 4'h0, 0, 0, -1);
        end

        // HLT: four cycles, then HALT is sticky until reset, which also
        // clears halted combinationally.
        applyStimulus(4'hF, 4'h0, 0, 0, -1);
        bus.opcode = 4'h0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("halt_sticky", HLTD);
            @(posedge clk); #1;
        end
        resetAndRelease(2);
        applyStimulus(4'h3, 4'h0, 0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
